// File: rtl/count_seq_pkg.sv
// Shared command and controller-state encodings for the up/down counter
// and the controller that sequences it.
package count_seq_pkg;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_UP    = 2'b01,
        CMD_DOWN  = 2'b10,
        CMD_HOLD  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        MOVE  = 3'd2,
        DWELL = 3'd3,
        CLEAR = 3'd4,
        DONE  = 3'd5
    } ctrl_state_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Request/accept/completion bundle between the two requesters (master)
// and the counter sequencing controller (slave).
interface count_seq_ctrl_if #(
    parameter int CNT_W = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_clear;
    logic [2*CNT_W-1:0] req_target;
    logic [1:0]         req_ready;
    logic [1:0]         done;
    logic [CNT_W-1:0]   done_pos;

    modport master (
        output req_valid, req_clear, req_target,
        input  req_ready, done, done_pos
    );

    modport slave (
        input  req_valid, req_clear, req_target,
        output req_ready, done, done_pos
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant; the pointer lives in the caller.
module rr_arbiter2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    always_comb begin
        grant = req_valid;
        // Contention favours whichever requester was not served last.
        if (req_valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/count_seq_ctrl.sv
// Steps an external up/down counter to requested targets by the shortest
// wrap-around path, tracking its value in a shadow register.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int DWELL_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    count_seq_ctrl_if.slave   bus,
    output logic [1:0]        up_down,
    output logic [CNT_W-1:0]  pos,
    output logic              busy
);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(1) << (CNT_W - 1);
    localparam logic [3:0]       DWELL_LOAD = 4'(DWELL_CYCLES > 0 ? DWELL_CYCLES - 1 : 0);

    ctrl_state_t      state_reg;
    logic [CNT_W-1:0] pos_reg;
    logic [CNT_W-1:0] target_reg;
    logic             owner_reg;
    logic             last_grant_reg;
    logic [3:0]       dwell_cnt_reg;

    logic [1:0]       grant;
    logic             grant_idx;
    logic [CNT_W-1:0] tgt_arr [2];
    logic [CNT_W-1:0] diff;
    logic             step_up;
    logic             at_target;
    cmd_t             cmd;

    rr_arbiter2 u_arb (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    assign grant_idx = grant[1];
    assign diff      = target_reg - pos_reg;
    assign at_target = (pos_reg == target_reg);
    // Distance of exactly half the ring resolves upward.
    assign step_up   = (diff <= HALF);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign tgt_arr[gi]       = bus.req_target[gi*CNT_W +: CNT_W];
            assign bus.req_ready[gi] = (state_reg == IDLE) && grant[gi];
            assign bus.done[gi]      = (state_reg == DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= INIT;
            pos_reg        <= '0;
            target_reg     <= '0;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            dwell_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                INIT: begin
                    pos_reg   <= '0;
                    state_reg <= IDLE;
                end
                IDLE: begin
                    if (|grant) begin
                        target_reg     <= tgt_arr[grant_idx];
                        owner_reg      <= grant_idx;
                        last_grant_reg <= grant_idx;
                        state_reg      <= bus.req_clear[grant_idx] ? CLEAR : MOVE;
                    end
                end
                MOVE: begin
                    if (!at_target) begin
                        pos_reg <= step_up ? pos_reg + CNT_W'(1) : pos_reg - CNT_W'(1);
                    end else if (DWELL_CYCLES == 0) begin
                        state_reg <= DONE;
                    end else begin
                        dwell_cnt_reg <= DWELL_LOAD;
                        state_reg     <= DWELL;
                    end
                end
                DWELL: begin
                    if (dwell_cnt_reg == 4'd0) begin
                        state_reg <= DONE;
                    end else begin
                        dwell_cnt_reg <= dwell_cnt_reg - 4'd1;
                    end
                end
                CLEAR: begin
                    pos_reg   <= '0;
                    state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

    always_comb begin
        cmd = CMD_HOLD;
        case (state_reg)
            INIT, CLEAR: cmd = CMD_CLEAR;
            MOVE: begin
                if (!at_target) begin
                    cmd = step_up ? CMD_UP : CMD_DOWN;
                end
            end
            default: cmd = CMD_HOLD;
        endcase
    end

    assign up_down      = cmd;
    assign pos          = pos_reg;
    assign busy         = (state_reg != IDLE);
    assign bus.done_pos = pos_reg;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Randomised and directed check of count_seq_ctrl against a transaction-level
// model of target stepping, dwell, clear and round-robin arbitration.
module tb_count_seq_ctrl;
    import count_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0][1:0] vld;
    logic [1:0][1:0] clr_op;
    logic [1:0][7:0] tgt;
    logic [1:0][1:0] ud;
    logic [1:0][1:0] rdy;
    logic [1:0][1:0] dn;
    logic [1:0][3:0] pos_o;
    logic [1:0][3:0] dpos;
    logic [1:0]      busy_o;

    count_seq_ctrl_if #(.CNT_W(4)) bus0 ();
    count_seq_ctrl_if #(.CNT_W(4)) bus1 ();

    assign bus0.req_valid  = vld[0];
    assign bus0.req_clear  = clr_op[0];
    assign bus0.req_target = tgt[0];
    assign bus1.req_valid  = vld[1];
    assign bus1.req_clear  = clr_op[1];
    assign bus1.req_target = tgt[1];
    assign rdy[0]  = bus0.req_ready;
    assign rdy[1]  = bus1.req_ready;
    assign dn[0]   = bus0.done;
    assign dn[1]   = bus1.done;
    assign dpos[0] = bus0.done_pos;
    assign dpos[1] = bus1.done_pos;

    count_seq_ctrl #(.CNT_W(4), .DWELL_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .up_down(ud[0]), .pos(pos_o[0]), .busy(busy_o[0])
    );

    count_seq_ctrl #(.CNT_W(4), .DWELL_CYCLES(2)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .up_down(ud[1]), .pos(pos_o[1]), .busy(busy_o[1])
    );

    int checks = 0;
    int passed = 0;
    int m_pos  [2];
    int m_last [2];

    task automatic check_eq(input int d, input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passed++;
        else $display("FAIL dut%0d %s: got %0d expected %0d (t=%0t)", d, tag, obs, exp, $time);
    endtask

    // Plays out one accepted transaction from the cycle after accept to done.
    task automatic run_seq(input int d, input int r, input bit c, input int t);
        int p, diff, k, total, dw, exp_cmd, exp_done;
        bit up;
        p    = m_pos[d];
        dw   = (d == 0) ? 0 : 2;
        diff = (t - p) & 15;
        up   = (diff <= 8);
        k    = (diff == 0) ? 0 : (up ? diff : 16 - diff);
        total = c ? 2 : k + 2 + dw;
        for (int cy = 1; cy <= total; cy++) begin
            @(negedge clk);
            if (cy == 1) vld[d][r] = 1'b0;
            #1;
            if (c) exp_cmd = (cy == 1) ? int'(CMD_CLEAR) : int'(CMD_HOLD);
            else   exp_cmd = (cy <= k) ? (up ? int'(CMD_UP) : int'(CMD_DOWN)) : int'(CMD_HOLD);
            exp_done = (cy == total) ? (1 << r) : 0;
            check_eq(d, "up_down", ud[d], exp_cmd);
            check_eq(d, "done", dn[d], exp_done);
            check_eq(d, "ready_while_busy", rdy[d], 0);
            if (!c && cy <= k)
                check_eq(d, "pos_step", pos_o[d], (p + (up ? cy - 1 : -(cy - 1))) & 15);
            if (cy == total) check_eq(d, "done_pos", dpos[d], c ? 0 : t);
        end
        m_pos[d] = c ? 0 : t;
        $display("txn dut%0d req%0d %s target=%0d pos %0d->%0d cycles=%0d",
                 d, r, c ? "clear" : "goto", t, p, m_pos[d], total);
    endtask

    task automatic wait_ready(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rdy[d] != 2'b00) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check_eq(d, "ready_timeout", 0, 1);
    endtask

    task automatic single(input int d, input int r, input bit c, input int t);
        bit ok;
        @(negedge clk);
        vld[d][r]          = 1'b1;
        clr_op[d][r]       = c;
        tgt[d][r*4 +: 4]   = 4'(t);
        wait_ready(d, ok);
        if (!ok) begin
            vld[d] = 2'b00;
            return;
        end
        check_eq(d, "grant", rdy[d], 1 << r);
        check_eq(d, "idle_busy", busy_o[d], 0);
        check_eq(d, "idle_cmd", ud[d], int'(CMD_HOLD));
        m_last[d] = r;
        run_seq(d, r, c, t);
    endtask

    task automatic pair(input int d, input bit c0, input int t0, input bit c1, input int t1);
        bit ok;
        int g;
        bit cs [2];
        int ts [2];
        cs[0] = c0; cs[1] = c1; ts[0] = t0; ts[1] = t1;
        @(negedge clk);
        vld[d]    = 2'b11;
        clr_op[d] = {c1, c0};
        tgt[d]    = {4'(t1), 4'(t0)};
        wait_ready(d, ok);
        if (!ok) begin
            vld[d] = 2'b00;
            return;
        end
        g = (m_last[d] == 1) ? 0 : 1;
        check_eq(d, "pair_first_grant", rdy[d], 1 << g);
        m_last[d] = g;
        run_seq(d, g, cs[g], ts[g]);
        @(negedge clk);
        #1;
        check_eq(d, "pair_second_grant", rdy[d], 1 << (1 - g));
        if (rdy[d] != 2'(1 << (1 - g))) begin
            vld[d] = 2'b00;
            return;
        end
        m_last[d] = 1 - g;
        run_seq(d, 1 - g, cs[1-g], ts[1-g]);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        vld   = '0;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq(d, "rst_cmd", ud[d], int'(CMD_CLEAR));
            check_eq(d, "rst_busy", busy_o[d], 1);
            check_eq(d, "rst_pos", pos_o[d], 0);
            check_eq(d, "rst_ready", rdy[d], 0);
            check_eq(d, "rst_done", dn[d], 0);
        end
        repeat (ncyc) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq(d, "init_cmd", ud[d], int'(CMD_CLEAR));
            check_eq(d, "init_busy", busy_o[d], 1);
        end
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq(d, "post_init_cmd", ud[d], int'(CMD_HOLD));
            check_eq(d, "post_init_busy", busy_o[d], 0);
            check_eq(d, "post_init_pos", pos_o[d], 0);
            check_eq(d, "post_init_done", dn[d], 0);
            m_pos[d]  = 0;
            m_last[d] = 1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        vld    = '0;
        clr_op = '0;
        tgt    = '0;
        reset  = 1'b1;
        do_reset(3);

        single(0, 0, 1'b0, 3);
        single(0, 0, 1'b0, 1);
        single(0, 1, 1'b0, 14);
        single(0, 0, 1'b1, 0);
        single(0, 0, 1'b0, 8);
        single(0, 1, 1'b0, 15);
        single(0, 0, 1'b0, 2);
        single(0, 1, 1'b0, 2);

        single(1, 0, 1'b0, 2);
        single(1, 1, 1'b1, 0);

        // Abort mid-move: reset lands while the counter is still stepping.
        @(negedge clk);
        vld[0][0] = 1'b1; clr_op[0][0] = 1'b0; tgt[0][3:0] = 4'd6;
        wait_ready(0, ok);
        check_eq(0, "abort_grant", rdy[0], 1);
        @(negedge clk);
        vld[0] = 2'b00;
        #1;
        check_eq(0, "abort_step1", ud[0], int'(CMD_UP));
        @(negedge clk);
        #1;
        check_eq(0, "abort_step2", ud[0], int'(CMD_UP));
        do_reset(2);

        pair(0, 1'b0, 5, 1'b0, 9);
        pair(0, 1'b0, 2, 1'b1, 0);
        pair(1, 1'b0, 7, 1'b0, 12);

        for (int n = 0; n < 40; n++) begin
            int d, mode, r, t;
            bit c;
            d    = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 2));
            r    = int'($urandom_range(0, 1));
            c    = ($urandom_range(0, 3) == 0);
            t    = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (mode < 2) single(d, r, c, t);
            else pair(d, c, t, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
